// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I datapath types and the data-cache FSM encoding
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} dcache_state_t;
  function automatic rv32i_word byte_merge(input rv32i_word old_w, input rv32i_word new_w, input logic [3:0] be);
    rv32i_word r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data flops with combinational read and one byte-enabled write port
import rv32i_types::*;
module dcache_array #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W = $clog2(NUM_SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output rv32i_word        data,
  input  logic             we,
  input  logic [3:0]       be,
  input  rv32i_word        wdata,
  input  logic             set_valid,
  input  logic [TAG_W-1:0] wtag
);
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [NUM_SETS];
  rv32i_word data_q [NUM_SETS];
  assign valid = valid_q[idx];
  assign tag = tag_q[idx];
  assign data = data_q[idx];
  always_ff @(posedge clk) begin
    if (!reset_n) valid_q <= '0;
    else if (we && set_valid) valid_q[idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we) data_q[idx] <= byte_merge(data_q[idx], wdata, be);
    if (we && set_valid) tag_q[idx] <= wtag;
  end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-allocate data cache for the MEM stage
import rv32i_types::*;
module dcache_responder #(
  parameter int NUM_SETS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       read_b,
  input  logic       write,
  input  logic [3:0] wmask,
  input  rv32i_word  address_b,
  input  rv32i_word  wdata,
  output logic       resp_b,
  output rv32i_word  rdata_b,
  output logic       pmem_read,
  output logic       pmem_write,
  output rv32i_word  pmem_address,
  output rv32i_word  pmem_wdata,
  output logic [3:0] pmem_wmask,
  input  logic       pmem_resp,
  input  rv32i_word  pmem_rdata
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - IDX_W;
  dcache_state_t state, state_n;
  rv32i_word addr_q, wdata_q, cur_addr, line_data, arr_wdata;
  logic [3:0] wmask_q, arr_be;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag, line_tag;
  logic line_valid, hit, arr_we, arr_set_valid;
  logic unused_addr_bits;
  // The array port follows the live request in IDLE and the latched one otherwise
  assign cur_addr = state == IDLE ? address_b : addr_q;
  assign idx = cur_addr[IDX_W+1:2];
  assign req_tag = cur_addr[31:IDX_W+2];
  assign hit = line_valid && line_tag == req_tag;
  assign unused_addr_bits = ^cur_addr[1:0];
  dcache_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) array (
    .clk(clk),
    .reset_n(reset_n),
    .idx(idx),
    .valid(line_valid),
    .tag(line_tag),
    .data(line_data),
    .we(arr_we && reset_n),
    .be(arr_be),
    .wdata(arr_wdata),
    .set_valid(arr_set_valid),
    .wtag(req_tag)
  );
  always_comb begin
    state_n = state;
    resp_b = 1'b0;
    rdata_b = '0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    pmem_wmask = '0;
    arr_we = 1'b0;
    arr_be = 4'hF;
    arr_wdata = pmem_rdata;
    arr_set_valid = 1'b0;
    case (state)
      IDLE: begin
        if (write) state_n = WRITE;
        else if (read_b) begin
          resp_b = hit;
          rdata_b = hit ? line_data : '0;
          state_n = hit ? IDLE : FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        pmem_address = addr_q;
        if (pmem_resp) begin
          arr_we = 1'b1;
          arr_set_valid = 1'b1;
          resp_b = 1'b1;
          rdata_b = pmem_rdata;
          state_n = IDLE;
        end
      end
      WRITE: begin
        pmem_write = 1'b1;
        pmem_address = addr_q;
        pmem_wdata = wdata_q;
        pmem_wmask = wmask_q;
        if (pmem_resp) begin
          arr_we = hit;
          arr_be = wmask_q;
          arr_wdata = wdata_q;
          resp_b = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (write || read_b)) addr_q <= {address_b[31:2], 2'b00};
      if (state == IDLE && write) begin
        wdata_q <= wdata;
        wmask_q <= wmask;
      end
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized self-checking bench with a word-memory and cache-residency model
module tb_dcache_responder;
  import rv32i_types::*;
  logic clk = 1'b0;
  logic reset_n, read_b, write, resp_b, pmem_read, pmem_write, pmem_resp;
  logic [3:0] wmask, pmem_wmask;
  rv32i_word address_b, wdata, rdata_b, pmem_address, pmem_wdata, pmem_rdata;
  int checks = 0;
  int failures = 0;
  rv32i_word mem [int unsigned];
  bit m_valid [16];
  logic [29:0] m_addr [16];
  logic obs_hit, obs_ok;
  rv32i_word obs_data, obs_paddr, obs_pwdata;
  logic [3:0] obs_pwmask;

  always #5 clk = ~clk;

  dcache_responder #(.NUM_SETS(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .read_b(read_b),
    .write(write),
    .wmask(wmask),
    .address_b(address_b),
    .wdata(wdata),
    .resp_b(resp_b),
    .rdata_b(rdata_b),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_wmask(pmem_wmask),
    .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata)
  );

  function automatic int unsigned wkey(input rv32i_word a);
    return {2'b00, a[31:2]};
  endfunction

  function automatic rv32i_word mem_rd(input rv32i_word a);
    return mem.exists(wkey(a)) ? mem[wkey(a)] : ({a[31:2], 2'b00} ^ 32'h5A5A_1234);
  endfunction

  function automatic rv32i_word merge(input rv32i_word o, input rv32i_word n, input logic [3:0] m);
    rv32i_word bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (n & bm) | (o & ~bm);
  endfunction

  function automatic logic predict_hit(input rv32i_word a);
    return m_valid[a[5:2]] && m_addr[a[5:2]] == a[31:2];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // Load driver: acts as the memory, records what the DUT showed
  task automatic do_load(input rv32i_word a, input int lat, input bit gap);
    obs_ok = 1'b1;
    obs_paddr = '0;
    read_b = 1'b1;
    write = 1'b0;
    address_b = a;
    wdata = $urandom;
    wmask = 4'($urandom);
    @(negedge clk);
    obs_hit = resp_b;
    obs_data = rdata_b;
    if (pmem_read || pmem_write) obs_ok = 1'b0;
    if (!resp_b) begin
      @(posedge clk); #1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (!pmem_read || pmem_write || resp_b) obs_ok = 1'b0;
        @(posedge clk); #1;
      end
      pmem_resp = 1'b1;
      pmem_rdata = mem_rd(a);
      @(negedge clk);
      if (!pmem_read || pmem_write || !resp_b) obs_ok = 1'b0;
      obs_paddr = pmem_address;
      obs_data = rdata_b;
      m_valid[a[5:2]] = 1'b1;
      m_addr[a[5:2]] = a[31:2];
    end
    @(posedge clk); #1;
    read_b = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = $urandom;
    if (gap) begin
      @(negedge clk);
      if (resp_b || pmem_read || pmem_write) obs_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_store(input rv32i_word a, input rv32i_word d, input logic [3:0] m, input int lat, input bit gap);
    obs_ok = 1'b1;
    read_b = 1'b0;
    write = 1'b1;
    address_b = a;
    wdata = d;
    wmask = m;
    @(negedge clk);
    if (resp_b || pmem_read || pmem_write) obs_ok = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (!pmem_write || pmem_read || resp_b) obs_ok = 1'b0;
      @(posedge clk); #1;
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    if (!pmem_write || pmem_read || !resp_b) obs_ok = 1'b0;
    obs_paddr = pmem_address;
    obs_pwdata = pmem_wdata;
    obs_pwmask = pmem_wmask;
    mem[wkey(a)] = merge(mem_rd(a), d, m);
    @(posedge clk); #1;
    write = 1'b0;
    pmem_resp = 1'b0;
    if (gap) begin
      @(negedge clk);
      if (resp_b || pmem_read || pmem_write) obs_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    read_b = 1'b0;
    write = 1'b0;
    wmask = '0;
    address_b = '0;
    wdata = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_b, pmem_read, pmem_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000", {resp_b, pmem_read, pmem_write});
    end
    checks++;
    if ({pmem_address, pmem_wdata, pmem_wmask} !== 68'h0) begin
      failures++;
      $display("FAIL reset_pmem_bus got=%h/%h/%h exp=0", pmem_address, pmem_wdata, pmem_wmask);
    end
    checks++;
    if (rdata_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", rdata_b);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_fill_hit();
    mem[wkey(32'h40)] = 32'hDEAD_BEEF;
    do_load(32'h40, 3, 1'b1);
    checks++;
    if ({obs_hit, obs_ok} !== 2'b01) begin
      failures++;
      $display("FAIL fill_miss hit/proto got=%b exp=01", {obs_hit, obs_ok});
    end
    checks++;
    if (obs_data !== 32'hDEAD_BEEF || obs_paddr !== 32'h40) begin
      failures++;
      $display("FAIL fill_data got=%h@%h exp=deadbeef@00000040", obs_data, obs_paddr);
    end
    do_load(32'h40, 0, 1'b1);
    checks++;
    if ({obs_hit, obs_ok} !== 2'b11 || obs_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL refill_hit got=%b/%h exp=11/deadbeef", {obs_hit, obs_ok}, obs_data);
    end
  endtask

  task automatic test_store_hit();
    do_store(32'h40, 32'h0000_00AA, 4'b0001, 2, 1'b1);
    checks++;
    if ({obs_ok, obs_pwmask, obs_pwdata, obs_paddr} !== {1'b1, 4'b0001, 32'hAA, 32'h40}) begin
      failures++;
      $display("FAIL store_hit_bus got=%b/%b/%h/%h exp=1/0001/000000aa/00000040", obs_ok, obs_pwmask, obs_pwdata, obs_paddr);
    end
    do_load(32'h40, 1, 1'b1);
    checks++;
    if ({obs_hit, obs_ok} !== 2'b11 || obs_data !== 32'hDEAD_BEAA) begin
      failures++;
      $display("FAIL store_merge got=%b/%h exp=11/deadbeaa", {obs_hit, obs_ok}, obs_data);
    end
  endtask

  task automatic test_store_miss();
    do_store(32'h1040, 32'h1234_5678, 4'hF, 1, 1'b1);
    checks++;
    if (obs_ok !== 1'b1 || obs_paddr !== 32'h1040) begin
      failures++;
      $display("FAIL store_miss_bus got=%b/%h exp=1/00001040", obs_ok, obs_paddr);
    end
    do_load(32'h40, 0, 1'b1);
    checks++;
    if (obs_hit !== 1'b1 || obs_data !== 32'hDEAD_BEAA) begin
      failures++;
      $display("FAIL store_miss_line_kept got=%b/%h exp=1/deadbeaa", obs_hit, obs_data);
    end
    do_load(32'h1040, 2, 1'b1);
    checks++;
    if ({obs_hit, obs_ok} !== 2'b01 || obs_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL store_miss_no_alloc got=%b/%h exp=01/12345678", {obs_hit, obs_ok}, obs_data);
    end
  endtask

  task automatic test_flush();
    logic ok, got_resp;
    ok = 1'b1;
    read_b = 1'b1;
    address_b = 32'h80;
    @(posedge clk); #1;
    read_b = 1'b0;
    address_b = $urandom;
    repeat (2) begin
      @(negedge clk);
      if (!pmem_read || pmem_address !== 32'h80 || resp_b) ok = 1'b0;
      @(posedge clk); #1;
    end
    pmem_resp = 1'b1;
    pmem_rdata = mem_rd(32'h80);
    @(negedge clk);
    got_resp = resp_b;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    m_valid[0] = 1'b1;
    m_addr[0] = 30'h20;
    checks++;
    if ({ok, got_resp} !== 2'b11) begin
      failures++;
      $display("FAIL flush_fill_completes got=%b exp=11", {ok, got_resp});
    end
    do_load(32'h80, 0, 1'b1);
    checks++;
    if (obs_hit !== 1'b1 || obs_data !== mem_rd(32'h80)) begin
      failures++;
      $display("FAIL flush_then_hit got=%b/%h exp=1/%h", obs_hit, obs_data, mem_rd(32'h80));
    end
  endtask

  task automatic test_reset_mid_fill();
    read_b = 1'b1;
    address_b = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin
      failures++;
      $display("FAIL midfill_strobe_before got=%b exp=1", pmem_read);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    read_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, resp_b} !== 3'b000) begin
      failures++;
      $display("FAIL midfill_strobes_drop got=%b exp=000", {pmem_read, pmem_write, resp_b});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_model();
    do_load(32'h80, 1, 1'b1);
    checks++;
    if (obs_hit !== 1'b0 || obs_ok !== 1'b1) begin
      failures++;
      $display("FAIL midfill_valid_clear_80 got=%b/%b exp=0/1", obs_hit, obs_ok);
    end
    do_load(32'h40, 1, 1'b1);
    checks++;
    if (obs_hit !== 1'b0 || obs_data !== 32'hDEAD_BEAA) begin
      failures++;
      $display("FAIL midfill_load_40 got=%b/%h exp=0/deadbeaa", obs_hit, obs_data);
    end
  endtask

  task automatic test_held_hit();
    rv32i_word exp;
    exp = mem_rd(32'h40);
    read_b = 1'b1;
    write = 1'b0;
    address_b = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_b, pmem_read} !== 2'b10 || rdata_b !== exp) begin
        failures++;
        $display("FAIL held_hit cycle %0d got=%b/%h exp=10/%h", i, {resp_b, pmem_read}, rdata_b, exp);
      end
      @(posedge clk); #1;
    end
    read_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    rv32i_word a, d;
    a = 32'h0000_0234;
    d = $urandom;
    do_load(a, 0, 1'b0);
    do_store(a, d, 4'b0110, 0, 1'b0);
    checks++;
    if (obs_ok !== 1'b1 || obs_pwmask !== 4'b0110 || obs_pwdata !== d) begin
      failures++;
      $display("FAIL b2b_store got=%b/%b/%h exp=1/0110/%h", obs_ok, obs_pwmask, obs_pwdata, d);
    end
    do_load(a, 0, 1'b1);
    checks++;
    if ({obs_hit, obs_ok} !== 2'b11 || obs_data !== mem_rd(a)) begin
      failures++;
      $display("FAIL b2b_load got=%b/%h exp=11/%h", {obs_hit, obs_ok}, obs_data, mem_rd(a));
    end
  endtask

  task automatic test_random();
    rv32i_word a, d, exp;
    logic [3:0] m;
    logic pred;
    for (int n = 0; n < 200; n++) begin
      a = $urandom & 32'h0000_30FF;
      if ($urandom_range(0, 1) == 0) begin
        pred = predict_hit(a);
        exp = mem_rd(a);
        do_load(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        checks++;
        if ({obs_hit, obs_ok} !== {pred, 1'b1} || obs_data !== exp || (!pred && obs_paddr !== {a[31:2], 2'b00})) begin
          failures++;
          $display("FAIL rand_load %h got=%b%b/%h@%h exp=%b1/%h", a, obs_hit, obs_ok, obs_data, obs_paddr, pred, exp);
        end
      end else begin
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        do_store(a, d, m, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        checks++;
        if ({obs_ok, obs_pwmask, obs_pwdata, obs_paddr} !== {1'b1, m, d, a[31:2], 2'b00}) begin
          failures++;
          $display("FAIL rand_store %h got=%b/%b/%h/%h exp=1/%b/%h", a, obs_ok, obs_pwmask, obs_pwdata, obs_paddr, m, d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_store_hit();
    test_store_miss();
    test_flush();
    test_reset_mid_fill();
    test_held_hit();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
# dcache_responder

Responder side of the MEM-stage data port: a small direct-mapped, write-through, no-write-allocate data cache. It answers the MEM stage's `read_b`/`write` requests with `resp_b`/`rdata_b` and forwards misses and all stores to physical memory over a single-word `pmem_*` handshake. It sits between the MEM stage and the memory arbiter.

## Interface
Parameters:
- `NUM_SETS`, 16: number of lines. One 32-bit word per line; must be a power of two, at least 2. `IDX_W = $clog2(NUM_SETS)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `read_b`  in  1  load request; held until `resp_b`.
- `write`  in  1  store request; held until `resp_b`.
- `wmask`  in  4  byte enables for a store; bit i enables byte i.
- `address_b`  in  32  byte address; bits [1:0] are ignored.
- `wdata`  in  32  store data, already byte-lane aligned.
- `resp_b`  out  1  one-cycle completion pulse.
- `rdata_b`  out  32  load data; valid only when `resp_b` is high for a load.
- `pmem_read`  out  1  memory read strobe; held until `pmem_resp`.
- `pmem_write`  out  1  memory write strobe; held until `pmem_resp`.
- `pmem_address`  out  32  word-aligned address, bits [1:0] = 0.
- `pmem_wdata`  out  32  store data.
- `pmem_wmask`  out  4  store byte enables.
- `pmem_resp`  in  1  memory completion pulse.
- `pmem_rdata`  in  32  read data; valid with `pmem_resp`.

## Operation
- Address split: index = `address_b[IDX_W+1:2]`, tag = `address_b[31:IDX_W+2]`.
- Hit condition: `valid[index]` is set and `tag[index]` equals the request tag.
- States: IDLE, FILL, WRITE.
- IDLE, `write` high: latch address, wdata and wmask; go to WRITE. `write` takes priority if `read_b` is also high (that combination is illegal).
- IDLE, `read_b` high and hit: `resp_b = 1` and `rdata_b = data[index]` in the same cycle (combinational from the flop array); stay in IDLE.
- IDLE, `read_b` high and miss: latch the address; go to FILL.
- FILL:
  - `pmem_read = 1` with the latched address.
  - On `pmem_resp`: write `pmem_rdata` into the line, set valid, update tag; `resp_b = 1` with `rdata_b = pmem_rdata` in that cycle; go to IDLE.
- WRITE:
  - `pmem_write = 1` with the latched address, wdata and wmask.
  - On `pmem_resp`:
    - If the latched address hits, merge the enabled bytes into the line.
    - A miss leaves the array untouched (no allocate).
    - `resp_b = 1`; go to IDLE.
- Once in FILL/WRITE, the latched transaction always completes, even if the requester deasserts or changes its request (pipeline flush). `resp_b` still pulses and the requester must ignore it.
- If the requester holds a request past `resp_b` (its pipeline is stalled), the request is serviced again. Loads and stores are idempotent, so this is legal.
- `wmask == 4'b0000` store: full memory transaction with a zero mask; the array is unchanged.

## Timing
- Reset (`reset_n == 0` at an edge):
  - state becomes IDLE and all valid bits clear.
  - Outputs in the cycle after the reset edge: `resp_b`, `pmem_read`, `pmem_write` = 0; `pmem_address`, `pmem_wdata`, `pmem_wmask` = 0; `rdata_b` = 0.
  - Tags and data are not reset.
- Reset during FILL/WRITE abandons the transaction; strobes drop after that edge. The memory side must tolerate an aborted strobe.
- Read hit: 0 added cycles; `resp_b` in the request's first cycle.
- Read miss: `resp_b` in the same cycle as `pmem_resp`. The `pmem_read` strobe rises one cycle after the request.
- Store: `resp_b` in the same cycle as `pmem_resp`. The `pmem_write` strobe rises one cycle after the request.
- `resp_b` is high for exactly one cycle per completion and never in the cycle after a FILL/WRITE completion, unless a new hit occurs.
- `pmem_read` and `pmem_write` are never high together. Both are low in IDLE.

## Structure
- Add `dcache_state_t` (IDLE, FILL, WRITE) to the shared `rv32i_types` package. Use `rv32i_word` for all 32-bit data and address ports.
- Sub-module `dcache_array`: valid/tag/data flops, combinational read, one write port with a 4-bit byte enable and a set-valid input, and synchronous active-low valid clear.
- The top level holds the FSM, the request latch, and the hit compare.

## Test plan
- Reset, then load 0x0000_0040: `pmem_read` at 0x40 the next cycle; return 0xDEAD_BEEF after 3 cycles → `resp_b` with `rdata_b` = 0xDEAD_BEEF in that same cycle. Repeat the load → `resp_b` in the same cycle, no `pmem_read`.
- After the fill above, store 0x0000_00AA with `wmask` = 0001 at 0x40 → `pmem_write` with mask 0001; after `pmem_resp`, a load of 0x40 hits and returns 0xDEAD_BEAA.
- Store to 0x0000_1040 (same index, different tag) → memory is written, the line at 0x40 is unchanged, and a load of 0x1040 misses.
- Load 0x80, then drop `read_b` in FILL → FILL still completes, `resp_b` pulses, and a later load of 0x80 hits.
- `reset_n` low mid-FILL → strobes low the next cycle, all valid bits clear, and a load of 0x40 misses.
- Hold a load hit high for 3 cycles → `resp_b` high in all 3 cycles with identical data; `pmem_read` never asserts.
